xc_readout_scheduler: RTL

- Sequences the cross-correlator's integration windows and the serial readout of each finished window.
- Counts sampling ticks to frame each window and drives the window-active flag and snapshot strobe into the correlator.
- Walks the snapshot buffer one line at a time and serialises each value into bytes toward the UART transmitter.
- Sits inside main, between the correlator datapath and the UART TX.

---
 rtl/xc_readout_scheduler.sv | 172 +++++++++++++++++
 1 files changed

// File: rtl/xc_readout_scheduler.sv
// Integration-window framing and serial packet readout for the cross-correlator.
// Optional trailing XOR checksum byte: define XC_READOUT_CHECKSUM_EN.
module xc_readout_scheduler #(
  parameter int          NUM_LINES  = 4,
  parameter int          RESOLUTION = 24,
  parameter int          LEN_WIDTH  = 24,
  parameter logic [7:0]  HEADER     = 8'hA5,
  localparam int         IDX_W      = (NUM_LINES > 1) ? $clog2(NUM_LINES) : 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enable,
  input  logic                  sample_tick,
  input  logic [LEN_WIDTH-1:0]  cfg_len,
  output logic                  integrating,
  output logic                  snapshot,
  output logic                  overrun,
  output logic [IDX_W-1:0]      rd_index,
  input  logic [RESOLUTION-1:0] rd_data,
  output logic [7:0]            tx_data,
  output logic                  tx_valid,
  input  logic                  tx_ready,
  output logic                  busy
);

  localparam int BYTES = (RESOLUTION + 7) / 8;
  localparam int WW    = BYTES * 8;
  localparam int BC_W  = (BYTES > 1) ? $clog2(BYTES) : 1;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_HDR   = 3'd1;
  localparam logic [2:0] S_FETCH = 3'd2;
  localparam logic [2:0] S_WAIT  = 3'd3;
  localparam logic [2:0] S_BYTE  = 3'd4;
`ifdef XC_READOUT_CHECKSUM_EN
  localparam logic [2:0] S_CSUM  = 3'd5;
`endif

  logic [LEN_WIDTH-1:0] count;
  logic                 run;
  logic                 last_tick;
  logic                 win_end;
  logic [2:0]           state;
  logic [WW-1:0]        shreg;
  logic [BC_W-1:0]      bcnt;
  logic                 xfer;
`ifdef XC_READOUT_CHECKSUM_EN
  logic [7:0]           csum;
`endif

  assign run       = enable && (cfg_len != '0);
  assign last_tick = (count == cfg_len - LEN_WIDTH'(1));
  assign win_end   = run && sample_tick && last_tick;
  // snapshot high counts as busy: the FSM leaves IDLE in that cycle
  assign busy      = (state != S_IDLE) || snapshot;
  assign xfer      = tx_valid && tx_ready;

  // Byte presented to the UART and its valid flag, decoded from state
  always_comb begin
    tx_data  = 8'h00;
    tx_valid = 1'b0;
    case (state)
      S_HDR: begin
        tx_data  = HEADER;
        tx_valid = 1'b1;
      end
      S_BYTE: begin
        tx_data  = shreg[WW-1 -: 8];
        tx_valid = 1'b1;
      end
`ifdef XC_READOUT_CHECKSUM_EN
      S_CSUM: begin
        tx_data  = csum;
        tx_valid = 1'b1;
      end
`endif
      default: begin
        tx_data  = 8'h00;
        tx_valid = 1'b0;
      end
    endcase
  end

  // Window tick counter, snapshot strobe and sticky overrun flag
  always_ff @(posedge clk) begin
    if (reset) begin
      count       <= '0;
      integrating <= 1'b0;
      snapshot    <= 1'b0;
      overrun     <= 1'b0;
    end else begin
      integrating <= run;
      snapshot    <= win_end && !busy;
      if (win_end && busy)
        overrun <= 1'b1;
      if (!run)
        count <= '0;
      else if (sample_tick)
        count <= last_tick ? '0 : count + LEN_WIDTH'(1);
    end
  end

  // Readout FSM: header, then per line fetch, wait, and MSB-first bytes
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= S_IDLE;
      rd_index <= '0;
      shreg    <= '0;
      bcnt     <= '0;
`ifdef XC_READOUT_CHECKSUM_EN
      csum     <= 8'h00;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          if (snapshot)
            state <= S_HDR;
        end
        S_HDR: begin
          if (xfer) begin
            rd_index <= '0;
            state    <= S_FETCH;
`ifdef XC_READOUT_CHECKSUM_EN
            csum     <= HEADER;
`endif
          end
        end
        S_FETCH: begin
          state <= S_WAIT;
        end
        S_WAIT: begin
          shreg <= WW'(rd_data);
          bcnt  <= '0;
          state <= S_BYTE;
        end
        S_BYTE: begin
          if (xfer) begin
            shreg <= shreg << 8;
`ifdef XC_READOUT_CHECKSUM_EN
            csum  <= csum ^ tx_data;
`endif
            if (bcnt == BC_W'(BYTES - 1)) begin
              bcnt <= '0;
              if (rd_index != IDX_W'(NUM_LINES - 1)) begin
                rd_index <= rd_index + IDX_W'(1);
                state    <= S_FETCH;
              end else begin
`ifdef XC_READOUT_CHECKSUM_EN
                state <= S_CSUM;
`else
                state <= S_IDLE;
`endif
              end
            end else begin
              bcnt <= bcnt + BC_W'(1);
            end
          end
        end
`ifdef XC_READOUT_CHECKSUM_EN
        S_CSUM: begin
          if (xfer)
            state <= S_IDLE;
        end
`endif
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
